// File: rtl/angle_calc_sched.sv
// Per-frame pan-angle sequencer: walks each fixture through calc_setup and a shared divider, then writes the result.
// Optional build macro ANGLE_DIST_OUT_EN adds the squared-distance output (x_dif_sq + y_dif_sq).
module angle_calc_sched #(
  parameter int NUM_LIGHTS  = 4,
  parameter int SETUP_LAT   = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [10:0] x_com,
  input  logic [9:0]  y_com,
  input  logic [10:0] light_x,
  input  logic [9:0]  light_y,
  output logic [1:0]  light_sel,
  output logic [10:0] x_com_q,
  output logic [9:0]  y_com_q,
  output logic [10:0] x_light_q,
  output logic [9:0]  y_light_q,
  input  logic [10:0] pan_dividend,
  input  logic [10:0] pan_divisor,
  output logic        div_start,
  output logic [10:0] div_dividend,
  output logic [10:0] div_divisor,
  input  logic        div_done,
  input  logic [10:0] div_quotient,
  output logic        pan_we,
  output logic [1:0]  pan_idx,
  output logic [10:0] pan_val,
  output logic        busy,
  output logic        overrun,
  output logic        div_err,
  output logic [2:0]  state_dbg
`ifdef ANGLE_DIST_OUT_EN
  ,
  input  logic [21:0] x_dif_sq,
  input  logic [19:0] y_dif_sq,
  output logic [22:0] dist_sq
`endif
);

  localparam int CNT_MAX = (SETUP_LAT > DIV_TIMEOUT) ? SETUP_LAT : DIV_TIMEOUT;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETUP_END = CW'((SETUP_LAT > 0) ? SETUP_LAT - 1 : 0);
  localparam logic [CW-1:0] TMO_END   = CW'((DIV_TIMEOUT > 0) ? DIV_TIMEOUT - 1 : 0);
  localparam logic [1:0]    LAST_SEL  = 2'(NUM_LIGHTS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SETUP_WAIT = 3'd2,
    DIV_START  = 3'd3,
    DIV_WAIT   = 3'd4,
    WRITE      = 3'd5,
    NEXT       = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            pending;
  logic [10:0]     pend_x;
  logic [9:0]      pend_y;
  logic [10:0]     div_dividend_r, div_divisor_r;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Divider handshake: div_start is a one-cycle request with operands valid in that same cycle
  // and held until the request ends; div_done is only honoured while waiting in DIV_WAIT.
  assign div_start    = (state == DIV_START) && (pan_divisor != '0);
  assign div_dividend = (state == DIV_START) ? pan_dividend : div_dividend_r;
  assign div_divisor  = (state == DIV_START) ? pan_divisor  : div_divisor_r;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (frame_valid || pending) state_n = LOAD;
      LOAD:       state_n = (SETUP_LAT == 0) ? DIV_START : SETUP_WAIT;
      SETUP_WAIT: if (cnt == SETUP_END) state_n = DIV_START;
      DIV_START:  state_n = (pan_divisor == '0) ? WRITE : DIV_WAIT;
      DIV_WAIT:   if (div_done || cnt == TMO_END) state_n = WRITE;
      WRITE:      state_n = NEXT;
      NEXT:       state_n = (light_sel == LAST_SEL) ? IDLE : LOAD;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      pending        <= 1'b0;
      pend_x         <= '0;
      pend_y         <= '0;
      light_sel      <= '0;
      x_com_q        <= '0;
      y_com_q        <= '0;
      x_light_q      <= '0;
      y_light_q      <= '0;
      div_dividend_r <= '0;
      div_divisor_r  <= '0;
      pan_we         <= 1'b0;
      pan_idx        <= '0;
      pan_val        <= '0;
      overrun        <= 1'b0;
      div_err        <= 1'b0;
    end else begin
      state  <= state_n;
      pan_we <= (state == WRITE);
      if (state == WRITE) pan_idx <= light_sel;

      case (state)
        IDLE: begin
          light_sel <= '0;
          // A fresh centroid arriving now beats the older pending one.
          if (frame_valid) begin
            x_com_q <= x_com;
            y_com_q <= y_com;
            pending <= 1'b0;
          end else if (pending) begin
            x_com_q <= pend_x;
            y_com_q <= pend_y;
            pending <= 1'b0;
          end
        end
        LOAD: begin
          x_light_q <= light_x;
          y_light_q <= light_y;
          cnt       <= '0;
        end
        SETUP_WAIT: cnt <= cnt + 1'b1;
        DIV_START: begin
          cnt            <= '0;
          div_dividend_r <= pan_dividend;
          div_divisor_r  <= pan_divisor;
          if (pan_divisor == '0) pan_val <= 11'h7FF;
        end
        DIV_WAIT: begin
          cnt <= cnt + 1'b1;
          if (div_done) begin
            pan_val <= div_quotient;
          end else if (cnt == TMO_END) begin
            pan_val <= '0;
            div_err <= 1'b1;
          end
        end
        NEXT: if (light_sel != LAST_SEL) light_sel <= light_sel + 1'b1;
        default: ;
      endcase

      if (frame_valid && state != IDLE) begin
        if (pending) overrun <= 1'b1;
        pending <= 1'b1;
        pend_x  <= x_com;
        pend_y  <= y_com;
      end
    end
  end

`ifdef ANGLE_DIST_OUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dist_sq <= '0;
    end else if (state == DIV_START) begin
      dist_sq <= 23'(x_dif_sq) + 23'(y_dif_sq);
    end
  end
`endif

endmodule

// File: tb/tb_angle_calc_sched.sv
// Directed bench for angle_calc_sched: divider and light table modelled here, pan writes scored against an expected queue.
module tb_angle_calc_sched;

  logic        clk, reset, frame_valid;
  logic [10:0] x_com;
  logic [9:0]  y_com;
  logic [10:0] light_x;
  logic [9:0]  light_y;
  logic [1:0]  light_sel;
  logic [10:0] x_com_q, x_light_q;
  logic [9:0]  y_com_q, y_light_q;
  logic [10:0] pan_dividend, pan_divisor;
  logic        div_start, div_done;
  logic [10:0] div_dividend, div_divisor, div_quotient;
  logic        pan_we;
  logic [1:0]  pan_idx;
  logic [10:0] pan_val;
  logic        busy, overrun, div_err;
  logic [2:0]  state_dbg;
`ifdef ANGLE_DIST_OUT_EN
  logic [21:0] x_dif_sq;
  logic [19:0] y_dif_sq;
  logic [22:0] dist_sq;
  logic [22:0] dist_seen;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];
  int          n_div_start = 0;

  // divider model controls
  int          div_lat = 3;
  int          div_cnt = 0;
  logic        div_done_m = 1'b0;
  logic        div_poke = 1'b0;
  logic        hold_en = 1'b0;
  logic [1:0]  hold_idx = 2'd0;
  logic        zero_en = 1'b0;
  logic [1:0]  zero_idx = 2'd1;

  assign light_x      = 11'(100 + 50 * int'(light_sel));
  assign light_y      = 10'(20 + 10 * int'(light_sel));
  assign pan_dividend = 11'd35;
  assign pan_divisor  = (zero_en && light_sel == zero_idx) ? 11'd0 : 11'd5;
  assign div_quotient = 11'd7;
  assign div_done     = div_done_m | div_poke;

  angle_calc_sched dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid),
    .x_com(x_com), .y_com(y_com), .light_x(light_x), .light_y(light_y),
    .light_sel(light_sel), .x_com_q(x_com_q), .y_com_q(y_com_q),
    .x_light_q(x_light_q), .y_light_q(y_light_q),
    .pan_dividend(pan_dividend), .pan_divisor(pan_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient),
    .pan_we(pan_we), .pan_idx(pan_idx), .pan_val(pan_val),
    .busy(busy), .overrun(overrun), .div_err(div_err), .state_dbg(state_dbg)
`ifdef ANGLE_DIST_OUT_EN
    , .x_dif_sq(x_dif_sq), .y_dif_sq(y_dif_sq), .dist_sq(dist_sq)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // divider model: div_done rises div_lat cycles after the div_start cycle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      div_done_m = 1'b0;
      if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0) div_done_m = 1'b1;
      end
      if (div_start && !(hold_en && light_sel == hold_idx)) div_cnt = div_lat;
    end
  end

  // write monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset && pan_we) begin
        got_q.push_back({pan_idx, pan_val});
`ifdef ANGLE_DIST_OUT_EN
        dist_seen = dist_sq;
`endif
      end
      if (reset && div_start) n_div_start++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_frame(input logic [10:0] x, input logic [9:0] y);
    frame_valid = 1'b1;
    x_com = x;
    y_com = y;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) tick();
    check({tag, "_wr_count"}, got_q.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic push_frame_exp(input logic [10:0] v0, v1, v2, v3);
    exp_q.push_back({2'd0, v0});
    exp_q.push_back({2'd1, v1});
    exp_q.push_back({2'd2, v2});
    exp_q.push_back({2'd3, v3});
  endtask

  task automatic check_writes(input string tag);
    logic [12:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 13'bx;
      check({tag, "_write"}, g, e);
    end
    check({tag, "_extra"}, got_q.size(), 0);
    got_q.delete();
  endtask

  initial begin
    int first_k;
    reset = 1'b0;
    frame_valid = 1'b0;
    x_com = '0;
    y_com = '0;
`ifdef ANGLE_DIST_OUT_EN
    x_dif_sq = 22'd40000;
    y_dif_sq = 20'd10000;
`endif
    #1;
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    check("rst_pan_we", pan_we, 0);
    check("rst_xq", x_com_q, 0);
    check("rst_sticky", {overrun, div_err}, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // single frame: timing, operands, four writes of quotient 7
    first_k = 0;
    frame_valid = 1'b1;
    x_com = 11'd400;
    y_com = 10'd500;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) frame_valid = 1'b0;
      if (k == 1) begin
        check("t1_load_state", state_dbg, 1);
        check("t1_xq", x_com_q, 400);
        check("t1_yq", y_com_q, 500);
      end
      if (k == 2) check("t1_light_q", {x_light_q, y_light_q}, {11'd100, 10'd20});
      if (k == 4) check("t1_div_start", {div_start, div_dividend, div_divisor}, {1'b1, 11'd35, 11'd5});
      if (k == 5) check("t1_div_start_pulse", div_start, 0);
      if (k == 36) check("t1_last_we_busy", {pan_we, busy}, 2'b11);
      if (k == 37) check("t1_busy_fall", {busy, state_dbg}, 4'b0000);
      if (pan_we && first_k == 0) first_k = k;
    end
    check("t1_latency", first_k, 9);
`ifdef ANGLE_DIST_OUT_EN
    check("t1_dist_sq", dist_seen, 50000);
`endif
    push_frame_exp(11'd7, 11'd7, 11'd7, 11'd7);
    check_writes("t1");

    // zero divisor on fixture 1: saturate, no divider request
    zero_en = 1'b1;
    n_div_start = 0;
    pulse_frame(11'd10, 10'd10);
    wait_idle("t2", 100);
    check("t2_div_starts", n_div_start, 3);
    push_frame_exp(11'd7, 11'h7FF, 11'd7, 11'd7);
    check_writes("t2");
    zero_en = 1'b0;

    // stray div_done in IDLE is ignored
    div_poke = 1'b1;
    tick();
    div_poke = 1'b0;
    check("t3_poke_state", {state_dbg, pan_we}, 4'b0000);

    // withheld div_done on fixture 0: timeout after 64 cycles, then continue
    check("t4_err_before", div_err, 0);
    hold_en = 1'b1;
    first_k = 0;
    frame_valid = 1'b1;
    for (int k = 1; k <= 100 && first_k == 0; k++) begin
      tick();
      frame_valid = 1'b0;
      if (pan_we) first_k = k;
    end
    check("t4_timeout_latency", first_k, 70);
    check("t4_err_set", div_err, 1);
    wait_idle("t4", 100);
    hold_en = 1'b0;
    push_frame_exp(11'd0, 11'd7, 11'd7, 11'd7);
    check_writes("t4");

    // pending frame coincident with new frame in IDLE: newest wins, no overrun
    pulse_frame(11'd1, 10'd2);
    tick();
    tick();
    pulse_frame(11'd111, 10'd22);
    wait_writes("t5a", 4, 100);
    check("t5_idle_gap", state_dbg, 0);
    pulse_frame(11'd222, 10'd33);
    check("t5_new_centroid", {state_dbg, x_com_q, y_com_q}, {3'd1, 11'd222, 10'd33});
    check("t5_no_overrun", overrun, 0);
    wait_writes("t5b", 8, 100);
    wait_idle("t5", 20);
    tick();
    tick();
    check("t5_no_third", busy, 0);
    push_frame_exp(11'd7, 11'd7, 11'd7, 11'd7);
    push_frame_exp(11'd7, 11'd7, 11'd7, 11'd7);
    check_writes("t5");

    // two frames while busy: overrun, newer centroid processed
    pulse_frame(11'd10, 10'd20);
    tick();
    tick();
    pulse_frame(11'd100, 10'd50);
    check("t6_overrun_one", overrun, 0);
    tick();
    pulse_frame(11'd300, 10'd60);
    check("t6_overrun", overrun, 1);
    wait_writes("t6a", 4, 100);
    check("t6_gap", state_dbg, 0);
    tick();
    check("t6_second", {state_dbg, x_com_q, y_com_q}, {3'd1, 11'd300, 10'd60});
    wait_writes("t6b", 8, 100);
    wait_idle("t6", 20);
    tick();
    check("t6_no_third", busy, 0);
    push_frame_exp(11'd7, 11'd7, 11'd7, 11'd7);
    push_frame_exp(11'd7, 11'd7, 11'd7, 11'd7);
    check_writes("t6");
    check("t6_overrun_sticky", {overrun, div_err}, 2'b11);

    // reset during DIV_WAIT of fixture 2
    pulse_frame(11'd5, 10'd6);
    wait_writes("t7a", 2, 100);
    tick();
    tick();
    tick();
    tick();
    check("t7_in_div_wait", {state_dbg, light_sel}, {3'd4, 2'd2});
    reset = 1'b0;
    #1;
    check("t7_rst_ctrl", {busy, pan_we, div_start, light_sel, state_dbg}, 0);
    check("t7_rst_data", {x_com_q, y_com_q, x_light_q, y_light_q, pan_val}, 0);
    check("t7_rst_sticky", {overrun, div_err}, 0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    exp_q.push_back({2'd0, 11'd7});
    exp_q.push_back({2'd1, 11'd7});
    check_writes("t7");
    pulse_frame(11'd7, 10'd8);
    check("t7_restart", {state_dbg, light_sel, x_com_q}, {3'd1, 2'd0, 11'd7});
    wait_writes("t7b", 1, 40);
    check("t7_first_idx", (got_q.size() > 0) ? got_q[0] : 13'bx, {2'd0, 11'd7});
    wait_idle("t7", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/angle_calc_sched.md
ANGLE_CALC_SCHED -- requirements
Module: angle_calc_sched

Interface
REQ-001 SHALL have parameter NUM_LIGHTS, default 4, meaning number of fixtures sequenced per frame (1..4).
REQ-002 SHALL have parameter SETUP_LAT, default 2, meaning cycles from operand load to valid calc_setup outputs.
REQ-003 SHALL have parameter DIV_TIMEOUT, default 64, meaning max cycles waiting for div_done.
REQ-004 SHALL have port clk  in  1  system clock; the single clock for all logic.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port frame_valid  in  1  one-cycle pulse; x_com/y_com hold a new centroid.
REQ-007 SHALL have ports x_com  in  11 and y_com  in  10  tracked centroid.
REQ-008 SHALL have ports light_x  in  11 and light_y  in  10  position of fixture light_sel, combinational lookup.
REQ-009 SHALL have port light_sel  out  2  fixture index being processed.
REQ-010 SHALL have ports x_com_q  out  11, y_com_q  out  10, x_light_q  out  11, y_light_q  out  10  registered operands to calc_setup.
REQ-011 SHALL have ports pan_dividend  in  11, pan_divisor  in  11  from calc_setup.
REQ-012 SHALL have ports div_start  out  1 (pulse), div_dividend  out  11, div_divisor  out  11, div_done  in  1, div_quotient  in  11.
REQ-013 SHALL have ports pan_we  out  1 (pulse), pan_idx  out  2, pan_val  out  11  result write to DMX register file.
REQ-014 SHALL have ports busy  out  1, overrun  out  1 (sticky), div_err  out  1 (sticky).

Function
REQ-015 SHALL implement states IDLE, LOAD, SETUP_WAIT, DIV_START, DIV_WAIT, WRITE, NEXT.
REQ-016 IDLE: on frame_valid or pending flag -> LOAD; capture x_com/y_com into x_com_q/y_com_q, light_sel=0, clear pending.
REQ-017 LOAD (1 cycle): register light_x/light_y into x_light_q/y_light_q; -> SETUP_WAIT, counter cleared.
REQ-018 SETUP_WAIT: count SETUP_LAT cycles, then -> DIV_START.
REQ-019 DIV_START (1 cycle): if pan_divisor==0 -> WRITE with pan_val=11'h7FF, no div_start; else div_start=1, div_dividend/div_divisor latched from calc_setup, -> DIV_WAIT.
REQ-020 DIV_WAIT: on div_done -> WRITE with pan_val=div_quotient; if DIV_TIMEOUT cycles elapse without div_done, set div_err, pan_val=0, -> WRITE.
REQ-021 WRITE (1 cycle): pan_we=1, pan_idx=light_sel; -> NEXT.
REQ-022 NEXT: if light_sel==NUM_LIGHTS-1 -> IDLE; else light_sel+1 -> LOAD (x_com_q/y_com_q unchanged).
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 frame_valid while busy SHALL set pending (one deep); frame_valid while pending already set SHALL set overrun and keep the newer centroid.
REQ-025 Pending centroid SHALL be captured into a shadow register and transferred to x_com_q/y_com_q on IDLE exit.
REQ-026 frame_valid in IDLE coincident with pending SHALL use the new centroid; no overrun.
REQ-027 div_done outside DIV_WAIT SHALL be ignored.
REQ-028 Latency frame_valid(IDLE) to first pan_we SHALL be 3+SETUP_LAT+1+D cycles, D = div_done wait (>=1).

Reset
REQ-029 Reset low SHALL force IDLE immediately; all outputs 0, pending/overrun/div_err 0, registered operands 0.
REQ-030 Reset mid-frame SHALL abort with no pan_we; results for remaining fixtures are not produced.
REQ-031 overrun and div_err SHALL clear only on reset.

Configuration
REQ-032 Macro ANGLE_DIST_OUT_EN defined: ports x_dif_sq in 22, y_dif_sq in 20, dist_sq out 23 added; dist_sq = x_dif_sq+y_dif_sq latched in DIV_START, valid with pan_we.
REQ-033 Macro ANGLE_DIST_OUT_EN undefined: those ports and the adder are absent; all other behaviour identical.

Verification
REQ-034 Single frame, NUM_LIGHTS=4, x_com=400,y_com=500, div_done 3 cycles after div_start, quotient=7 -> four pan_we pulses, idx 0..3, pan_val=7, busy falls after last NEXT.
REQ-035 pan_divisor=0 on fixture 1 -> no div_start for idx 1, pan_val=11'h7FF at idx 1.
REQ-036 div_done withheld -> after 64 cycles div_err=1, pan_we with pan_val=0, sequencing continues to next fixture.
REQ-037 Two frame_valid pulses during busy (centroids 100/50 then 300/60) -> overrun=1, second frame processed with x_com_q=300,y_com_q=60.
REQ-038 Reset low during DIV_WAIT of fixture 2 -> outputs 0 same cycle, no further pan_we; next frame_valid restarts at idx 0.
REQ-039 ANGLE_DIST_OUT_EN defined, x_dif_sq=40000,y_dif_sq=10000 -> dist_sq=50000 on pan_we.
